// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the Sobel edge-detection writeback path:
//   - default frame geometry
//   - writeback FSM state encoding
//   - write-buffer entry layout (byte address + 8-bit pixel)
// -----------------------------------------------------------------------------
package edge_pkg;

  localparam int DEF_ROW_NUM = 480;
  localparam int DEF_COL_NUM = 640;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/edge_writeback_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t used as the Avalon write buffer.
// Ports:
//   clk, rst      clock, synchronous active-low reset (pointers/count only)
//   push, din     write request and entry; ignored when full unless a pop
//                 happens in the same cycle
//   pop, dout     read request and head entry (dout is the current head)
//   full, empty   occupancy flags
//   count         number of valid entries, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo
  import edge_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     din,
  input  logic                          pop,
  output wb_entry_t                     dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  wb_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/edge_writeback.sv
// -----------------------------------------------------------------------------
// edge_writeback
// Final stage of the Sobel edge core. Converts each 11-bit gradient pixel to
// 8 bits (saturate or binary threshold), buffers it, and writes it to the
// output frame buffer through an Avalon-MM write master.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   en                arm for one frame (sampled in IDLE)
//   binary_mode       1 = threshold output, 0 = saturate (latched at frame start)
//   threshold         binary threshold (latched at frame start)
//   in_valid/in_pixel/in_x/in_y   gradient stream from the edge core
//   stall             waitrequest back to the edge core
//   avm_address/avm_write/avm_writedata/avm_waitrequest   Avalon-MM write master
//   busy              any state except IDLE
//   frame_done        one-cycle pulse once the last pixel write has been accepted
//   overflow          sticky, an entry was dropped on a full buffer
// -----------------------------------------------------------------------------
module edge_writeback
  import edge_pkg::*;
#(
  parameter int          ROW_NUM    = DEF_ROW_NUM,
  parameter int          COL_NUM    = DEF_COL_NUM,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        binary_mode,
  input  logic [10:0] threshold,
  input  logic        in_valid,
  input  logic [10:0] in_pixel,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  output logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [7:0]  avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam int          DATA_W    = 11;
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [19:0] FRAME_PIX = 20'(ROW_NUM * COL_NUM);

  function automatic logic [7:0] sat8(input logic [DATA_W-1:0] v);
    return (v > DATA_W'(255)) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [7:0] thresh8(input logic [DATA_W-1:0] v,
                                         input logic [DATA_W-1:0] t);
    return (v >= t) ? 8'hFF : 8'h00;
  endfunction

  wb_state_t         state;
  wb_state_t         state_nx;
  logic              start;
  logic              mode_q;
  logic [DATA_W-1:0] thr_q;
  logic              take_p0;
  logic              last_p0;
  logic [31:0]       addr_p0;
  logic [7:0]        data_p0;
  logic              vld_p1;
  wb_entry_t         ent_p1;
  wb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop;
  logic [19:0]       pix_cnt;

  assign start = (state == IDLE) && en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= 1'b0;
    end else if (start) begin
      mode_q <= binary_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (start) thr_q <= threshold;
  end

  // ---- p0: input qualification, conversion and address generation ----
  assign take_p0 = (state == ACTIVE) && in_valid &&
                   (in_x < 11'(COL_NUM)) && (in_y < 11'(ROW_NUM));
  assign last_p0 = take_p0 && (in_x == 11'(COL_NUM - 1)) && (in_y == 11'(ROW_NUM - 1));
  assign addr_p0 = BASE_ADDR + 32'(in_y) * 32'(COL_NUM) + 32'(in_x);
  assign data_p0 = mode_q ? thresh8(in_pixel, thr_q) : sat8(in_pixel);

  // ---- p1: stage register, pushes into the write buffer next cycle ----
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= take_p0;
  end

  always_ff @(posedge clk) begin
    if (take_p0) begin
      ent_p1.addr <= addr_p0;
      ent_p1.data <= data_p0;
    end
  end

  // ---- p2: write buffer and Avalon master ----
  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   (ent_p1),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop           = avm_write && !avm_waitrequest;
  assign avm_write     = !fifo_empty;
  // Buffer storage is not reset; gate the head so the bus reads zero when idle.
  assign avm_address   = fifo_empty ? 32'd0 : head.addr;
  assign avm_writedata = fifo_empty ? 8'd0  : head.data;
  // Two spare slots absorb the stage register and one cycle of upstream reaction.
  assign stall         = (fifo_count >= CW'(FIFO_DEPTH - 2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (start) begin
      overflow <= 1'b0;
    end else if (vld_p1 && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_cnt <= '0;
    end else if (start) begin
      pix_cnt <= '0;
    end else if (pop) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && (state == DONE)) begin
      assert (pix_cnt == FRAME_PIX);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (last_p0) state_nx = FLUSH;
      end
      FLUSH: begin
        if (fifo_empty && !vld_p1) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_writeback.sv
module tb_edge_writeback;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_w, en_s, binary_mode, in_valid, avm_waitrequest;
  logic [10:0] threshold, in_pixel, in_x, in_y;

  logic        w_stall, w_write, w_busy, w_done, w_ovf;
  logic [31:0] w_addr;
  logic [7:0]  w_data;
  logic        s_stall, s_write, s_busy, s_done, s_ovf;
  logic [31:0] s_addr;
  logic [7:0]  s_data;

  edge_writeback #(.ROW_NUM(480), .COL_NUM(640), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut_w (
    .clk(clk), .rst(rst), .en(en_w), .binary_mode(binary_mode), .threshold(threshold),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x), .in_y(in_y),
    .stall(w_stall), .avm_address(w_addr), .avm_write(w_write), .avm_writedata(w_data),
    .avm_waitrequest(avm_waitrequest), .busy(w_busy), .frame_done(w_done), .overflow(w_ovf)
  );

  edge_writeback #(.ROW_NUM(4), .COL_NUM(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .binary_mode(binary_mode), .threshold(threshold),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_x(in_x), .in_y(in_y),
    .stall(s_stall), .avm_address(s_addr), .avm_write(s_write), .avm_writedata(s_data),
    .avm_waitrequest(avm_waitrequest), .busy(s_busy), .frame_done(s_done), .overflow(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          start;
    bit          mode;
    logic [10:0] thr;
    logic [10:0] pix;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  exp_d;
    logic [31:0] exp_a;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit mode, input logic [10:0] thr);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    binary_mode = mode;
    threshold = thr;
    en_w = 1'b1;
    tick();
    en_w = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write"}, w_write, 0);
    chk({tag, "_addr"},  w_addr,  0);
    chk({tag, "_data"},  w_data,  0);
    chk({tag, "_stall"}, w_stall, 0);
    chk({tag, "_busy"},  w_busy,  0);
    chk({tag, "_done"},  w_done,  0);
    chk({tag, "_ovf"},   w_ovf,   0);
  endtask

  initial begin
    int sent, nwr, stall_at, unstable, seen, fd_cyc, rec_cyc;
    bit finished, fd_early;
    logic [7:0] ed;

    vecs[0] = '{1'b1, 1'b0, 11'd0,   11'd300,  11'd0,   11'd0,   8'hFF, BASE};
    vecs[1] = '{1'b0, 1'b0, 11'd0,   11'd77,   11'd5,   11'd2,   8'h4D, BASE + 32'd1285};
    vecs[2] = '{1'b0, 1'b0, 11'd0,   11'd255,  11'd639, 11'd0,   8'hFF, BASE + 32'd639};
    vecs[3] = '{1'b0, 1'b0, 11'd0,   11'd256,  11'd1,   11'd1,   8'hFF, BASE + 32'd641};
    vecs[4] = '{1'b0, 1'b0, 11'd0,   11'd0,    11'd10,  11'd479, 8'h00, BASE + 32'd306570};
    vecs[5] = '{1'b1, 1'b1, 11'd100, 11'd99,   11'd2,   11'd0,   8'h00, BASE + 32'd2};
    vecs[6] = '{1'b0, 1'b1, 11'd100, 11'd100,  11'd3,   11'd0,   8'hFF, BASE + 32'd3};
    vecs[7] = '{1'b0, 1'b1, 11'd500, 11'd150,  11'd4,   11'd0,   8'hFF, BASE + 32'd4};
    vecs[8] = '{1'b0, 1'b1, 11'd20,  11'd50,   11'd0,   11'd1,   8'h00, BASE + 32'd640};
    vecs[9] = '{1'b0, 1'b1, 11'd0,   11'd2047, 11'd7,   11'd7,   8'hFF, BASE + 32'd4487};

    rst = 1'b0; en_w = 1'b0; en_s = 1'b0; binary_mode = 1'b0; threshold = '0;
    in_valid = 1'b0; in_pixel = '0; in_x = '0; in_y = '0; avm_waitrequest = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_s_write", s_write, 0);
    chk("reset_s_busy", s_busy, 0);
    rst = 1'b1;
    tick();

    // Inputs while IDLE are ignored
    in_valid = 1'b1; in_pixel = 11'd55; in_x = 11'd1; in_y = 11'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("idle_ignore_write", w_write, 0);
    chk("idle_busy", w_busy, 0);

    // Conversion and addressing vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].start) start_frame(vecs[i].mode, vecs[i].thr);
      threshold = vecs[i].thr;
      in_valid = 1'b1; in_pixel = vecs[i].pix; in_x = vecs[i].x; in_y = vecs[i].y;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_latency", i), w_write, 0);
      tick();
      chk($sformatf("v%0d_write", i), w_write, 1);
      chk($sformatf("v%0d_addr", i), w_addr, vecs[i].exp_a);
      chk($sformatf("v%0d_data", i), w_data, vecs[i].exp_d);
      tick();
    end
    chk("vec_busy", w_busy, 1);

    // Out-of-range coordinates are dropped without overflow
    start_frame(1'b0, 11'd0);
    seen = 0;
    in_valid = 1'b1; in_pixel = 11'd9; in_x = 11'd640; in_y = 11'd0;
    tick();
    in_x = 11'd0; in_y = 11'd480;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (w_write) seen++;
      tick();
    end
    chk("oor_writes", seen, 0);
    chk("oor_ovf", w_ovf, 0);

    // Back-pressure: source obeys stall while the slave is stalled
    start_frame(1'b0, 11'd0);
    avm_waitrequest = 1'b1;
    sent = 0; stall_at = -1; unstable = 0;
    for (int c = 0; c < 14; c++) begin
      if (w_stall && stall_at < 0) stall_at = sent;
      if (!w_stall && stall_at < 0) begin
        in_valid = 1'b1; in_pixel = 11'(10 + sent); in_x = 11'(sent); in_y = 11'd0;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (w_write && (w_addr !== BASE || w_data !== 8'd10)) unstable++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_stall_at", stall_at, 7);
    chk("bp_ovf", w_ovf, 0);
    chk("bp_stable", unstable, 0);
    chk("bp_hold_write", w_write, 1);
    avm_waitrequest = 1'b0;
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      if (w_write) begin
        if (nwr < 7) begin
          chk($sformatf("bp_data%0d", nwr), w_data, 10 + nwr);
          chk($sformatf("bp_addr%0d", nwr), w_addr, BASE + 32'(nwr));
        end
        nwr++;
      end
      tick();
    end
    chk("bp_count", nwr, 7);
    chk("bp_stall_release", w_stall, 0);

    // Overflow: source ignores stall
    start_frame(1'b0, 11'd0);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_pixel = 11'(40 + i); in_x = 11'(i); in_y = 11'd1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("ovf_set", w_ovf, 1);
    chk("ovf_stall", w_stall, 1);
    avm_waitrequest = 1'b0;
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      if (w_write) begin
        if (nwr < 8) begin
          chk($sformatf("ovf_data%0d", nwr), w_data, 40 + nwr);
          chk($sformatf("ovf_addr%0d", nwr), w_addr, BASE + 32'd640 + 32'(nwr));
        end
        nwr++;
      end
      tick();
    end
    chk("ovf_count", nwr, 8);
    chk("ovf_sticky", w_ovf, 1);

    // Reset mid-frame with three entries buffered
    start_frame(1'b0, 11'd0);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pixel = 11'(i + 1); in_x = 11'(i); in_y = 11'd3;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_buffered", w_write, 1);
    rst = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b1;
    avm_waitrequest = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (w_write || w_done) seen++;
      tick();
    end
    chk("midrst_quiet", seen, 0);
    chk("midrst_ovf_clear_en", w_ovf, 0);

    // Full 4x4 frame with random slave stalls
    rst = 1'b0;
    tick();
    rst = 1'b1;
    binary_mode = 1'b0;
    en_s = 1'b1;
    tick();
    en_s = 1'b0;
    chk("ff_busy", s_busy, 1);
    sent = 0; nwr = 0; fd_cyc = -1; rec_cyc = -1; finished = 1'b0; fd_early = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      if (fd_cyc >= 0) begin
        chk("ff_done_width", s_done, 0);
        chk("ff_busy_after", s_busy, 0);
        finished = 1'b1;
      end else if (s_done) begin
        fd_cyc = c;
        if (nwr < 16) fd_early = 1'b1;
      end
      if (!finished) begin
        if (sent < 16 && !s_stall) begin
          in_valid = 1'b1; in_pixel = 11'(20 * sent);
          in_x = 11'(sent % 4); in_y = 11'(sent / 4);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
        avm_waitrequest = 1'($urandom_range(0, 1));
        if (s_write && !avm_waitrequest) begin
          if (nwr < 16) begin
            ed = (20 * nwr > 255) ? 8'hFF : 8'(20 * nwr);
            chk($sformatf("ff_data%0d", nwr), s_data, ed);
            chk($sformatf("ff_addr%0d", nwr), s_addr, BASE + 32'(nwr));
          end
          nwr++;
          rec_cyc = c;
        end
        tick();
      end
    end
    in_valid = 1'b0;
    avm_waitrequest = 1'b0;
    chk("ff_finished", finished, 1);
    chk("ff_writes", nwr, 16);
    chk("ff_done_early", fd_early, 0);
    chk("ff_done_latency", ((fd_cyc - rec_cyc) >= 1 && (fd_cyc - rec_cyc) <= 3), 1);
    chk("ff_ovf", s_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
